// File: rtl/mushroom_spawner_if.sv
// Bundle of block, Mario and mushroom sprite signals for the question-block item source.
// The master drives block/Mario inputs; the slave (spawner) drives sprite outputs.
interface mushroom_spawner_if;
  logic [9:0] block_x;
  logic [9:0] block_y;
  logic       head_bump;
  logic [9:0] mario_x;
  logic [9:0] mario_y;
  logic [9:0] mushroom_x;
  logic [9:0] mushroom_y;
  logic       mushroom_visible;
  logic       mushroom_behind;
  logic       block_empty;
  logic [2:0] bump_offset;
  logic       collision;

  modport master (
    output block_x, block_y, head_bump, mario_x, mario_y,
    input  mushroom_x, mushroom_y, mushroom_visible, mushroom_behind,
           block_empty, bump_offset, collision
  );

  modport slave (
    input  block_x, block_y, head_bump, mario_x, mario_y,
    output mushroom_x, mushroom_y, mushroom_visible, mushroom_behind,
           block_empty, bump_offset, collision
  );
endinterface

// File: rtl/mushroom_spawner.sv
// Question-block mushroom: bumps the block, raises the mushroom out of it, walks it
// between screen bounds and pulses collision when Mario collects it. One step per frame.
module mushroom_spawner #(
  parameter int SIZE        = 16,
  parameter int BUMP_FRAMES = 8,
  parameter int RISE_FRAMES = 16,
  parameter int SPEED       = 1,
  parameter int LEFT_BOUND  = 0,
  parameter int RIGHT_BOUND = 639,
  parameter int MARIO_W     = 16,
  parameter int MARIO_H     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  mushroom_spawner_if.slave  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] BUMP = 3'd1;
  localparam logic [2:0] RISE = 3'd2;
  localparam logic [2:0] WALK = 3'd3;
  localparam logic [2:0] GONE = 3'd4;

  localparam logic [7:0]  BUMP_LAST   = 8'(BUMP_FRAMES - 1);
  localparam logic [7:0]  RISE_LAST   = 8'(RISE_FRAMES - 1);
  localparam logic [10:0] RIGHT_CLAMP = 11'(RIGHT_BOUND - SIZE + 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic [9:0] bx;
  logic [9:0] by;
  logic       dir_left;

  // Block rises for the first half of the bump and falls back for the second half.
  function automatic logic [2:0] bump_off(input logic [7:0] c);
    int ci;
    ci = int'(c);
    if (ci < BUMP_FRAMES / 2) return 3'(ci + 1);
    else                      return 3'(BUMP_FRAMES - ci);
  endfunction

  // 11-bit box compare so edge sums near 1023 cannot wrap.
  logic [10:0] mx, my, px, py;
  logic [10:0] x_right, x_right_edge;
  logic        overlap;
  logic        right_over;
  logic        left_under;

  always_comb begin
    mx           = {1'b0, bus.mushroom_x};
    my           = {1'b0, bus.mushroom_y};
    px           = {1'b0, bus.mario_x};
    py           = {1'b0, bus.mario_y};
    overlap      = (mx < px + 11'(MARIO_W)) && (px < mx + 11'(SIZE)) &&
                   (my < py + 11'(MARIO_H)) && (py < my + 11'(SIZE));
    x_right      = mx + 11'(SPEED);
    x_right_edge = x_right + 11'(SIZE - 1);
    right_over   = x_right_edge > 11'(RIGHT_BOUND);
    left_under   = mx < 11'(LEFT_BOUND + SPEED);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state                <= IDLE;
      cnt                  <= '0;
      dir_left             <= 1'b0;
      bx                   <= '0;
      by                   <= '0;
      bus.mushroom_x       <= '0;
      bus.mushroom_y       <= '0;
      bus.mushroom_visible <= 1'b0;
      bus.mushroom_behind  <= 1'b0;
      bus.block_empty      <= 1'b0;
      bus.bump_offset      <= '0;
      bus.collision        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.head_bump) begin
            state           <= BUMP;
            bx              <= bus.block_x;
            by              <= bus.block_y;
            cnt             <= '0;
            bus.bump_offset <= bump_off(8'd0);
            bus.block_empty <= 1'b1;
          end
        end
        BUMP: begin
          if (cnt == BUMP_LAST) begin
            state                <= RISE;
            cnt                  <= '0;
            bus.bump_offset      <= '0;
            bus.mushroom_x       <= bx;
            bus.mushroom_y       <= by;
            bus.mushroom_visible <= 1'b1;
            bus.mushroom_behind  <= 1'b1;
          end else begin
            cnt             <= cnt + 8'd1;
            bus.bump_offset <= bump_off(cnt + 8'd1);
          end
        end
        RISE: begin
          bus.mushroom_y <= bus.mushroom_y - 10'd1;
          if (cnt == RISE_LAST) begin
            state               <= WALK;
            cnt                 <= '0;
            dir_left            <= 1'b0;
            bus.mushroom_behind <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WALK: begin
          // Collection wins over movement: position freezes on the collect edge.
          if (overlap) begin
            state                <= GONE;
            bus.collision        <= 1'b1;
            bus.mushroom_visible <= 1'b0;
          end else if (!dir_left) begin
            if (right_over) begin
              bus.mushroom_x <= RIGHT_CLAMP[9:0];
              dir_left       <= 1'b1;
            end else begin
              bus.mushroom_x <= x_right[9:0];
            end
          end else begin
            if (left_under) begin
              bus.mushroom_x <= 10'(LEFT_BOUND);
              dir_left       <= 1'b0;
            end else begin
              bus.mushroom_x <= bus.mushroom_x - 10'(SPEED);
            end
          end
        end
        GONE: begin
          bus.collision <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mushroom_spawner.sv
// Scoreboard bench for mushroom_spawner: a frame-level model predicts the registered
// outputs for each edge, queues them, and they are compared after the edge.
module tb_mushroom_spawner;
  logic Clk = 1'b0;
  logic Reset;

  mushroom_spawner_if bus();

  mushroom_spawner dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int x, y, vis, beh, empty, off, col;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int n_chk = 0;
  int n_fail = 0;

  localparam int S_IDLE = 0, S_BUMP = 1, S_RISE = 2, S_WALK = 3, S_GONE = 4;
  int st, frame, bx, by;
  bit going_left;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    st = S_IDLE; frame = 0; bx = 0; by = 0; going_left = 0;
    m = '{x: 0, y: 0, vis: 0, beh: 0, empty: 0, off: 0, col: 0};
  endtask

  task automatic model_step(input bit r, input bit hb, input int bxi, input int byi,
                            input int pxi, input int pyi);
    if (r) begin
      model_reset();
      return;
    end
    case (st)
      S_IDLE: if (hb) begin
        st = S_BUMP; bx = bxi; by = byi; frame = 0; m.off = 1; m.empty = 1;
      end
      S_BUMP: begin
        frame++;
        if (frame == 8) begin
          st = S_RISE; frame = 0; m.off = 0; m.x = bx; m.y = by; m.vis = 1; m.beh = 1;
        end else begin
          m.off = (frame < 4) ? frame + 1 : 8 - frame;
        end
      end
      S_RISE: begin
        frame++;
        m.y = by - frame;
        if (frame == 16) begin
          st = S_WALK; m.beh = 0; going_left = 0;
        end
      end
      S_WALK: begin
        if (m.x < pxi + 16 && pxi < m.x + 16 && m.y < pyi + 16 && pyi < m.y + 16) begin
          st = S_GONE; m.col = 1; m.vis = 0;
        end else if (!going_left) begin
          if (m.x + 16 > 639) begin m.x = 624; going_left = 1; end
          else m.x = m.x + 1;
        end else begin
          if (m.x < 1) begin m.x = 0; going_left = 0; end
          else m.x = m.x - 1;
        end
      end
      default: m.col = 0;
    endcase
  endtask

  task automatic tick();
    exp_t e;
    model_step(Reset, bus.head_bump, int'(bus.block_x), int'(bus.block_y),
               int'(bus.mario_x), int'(bus.mario_y));
    sb.push_back(m);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check_val("mushroom_x", int'(bus.mushroom_x), e.x);
    check_val("mushroom_y", int'(bus.mushroom_y), e.y);
    check_val("visible", int'(bus.mushroom_visible), e.vis);
    check_val("behind", int'(bus.mushroom_behind), e.beh);
    check_val("block_empty", int'(bus.block_empty), e.empty);
    check_val("bump_offset", int'(bus.bump_offset), e.off);
    check_val("collision", int'(bus.collision), e.col);
  endtask

  task automatic mario_at(input int x, input int y);
    bus.mario_x = 10'(x);
    bus.mario_y = 10'(y);
  endtask

  task automatic mario_far();
    mario_at(1000, 1000);
  endtask

  task automatic bump_at(input int x, input int y);
    bus.block_x = 10'(x);
    bus.block_y = 10'(y);
    bus.head_bump = 1'b1;
    tick();
    bus.head_bump = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    Reset = 1'b1;
    bus.head_bump = 1'b0;
    bus.block_x = '0;
    bus.block_y = '0;
    mario_far();
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // Bump, then rise with Mario overlapping the rising mushroom.
    bump_at(200, 300);
    for (int i = 0; i < 24; i++) begin
      if (st == S_RISE) mario_at(m.x + 4, m.y + 4);
      else mario_far();
      tick();
    end
    check_val("walk_y", int'(bus.mushroom_y), 284);

    // Edge-touching boxes on each side.
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: mario_at(m.x + 16, m.y);
        1: mario_at(m.x - 16, m.y);
        2: mario_at(m.x, m.y + 16);
        default: mario_at(m.x, m.y - 16);
      endcase
      tick();
    end

    // Walk to the right bound, back to the left bound and turn again.
    mario_far();
    for (int i = 0; i < 1100; i++) tick();

    // Collect, then a head bump in GONE must not restart.
    mario_at(m.x + 8, m.y);
    tick();
    check_val("collect_pulse", int'(bus.collision), 1);
    mario_far();
    bump_at(200, 300);
    for (int i = 0; i < 4; i++) tick();

    // Fresh sequence, then Reset coincident with an overlap.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    bump_at(100, 200);
    mario_far();
    for (int i = 0; i < 28; i++) tick();
    mario_at(m.x + 8, m.y);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    mario_far();
    tick();
    bump_at(300, 400);
    for (int i = 0; i < 12; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
